// File: rtl/morra_cinese_param.sv
// morra_cinese_param: referee for a two-player rock-paper-scissors match.
// Every output is registered and changes one edge after its inputs are sampled.
// The match can end early on a score lead, or it ends when a configured manche count is reached.
//
// Parameters:
//   CNT_W       width of the score/manche counters (must hold MIN_MANCHE+15)
//   MIN_MANCHE  minimum valid manches before a lead can end the match; base of max
//   LEAD        score advantage that ends the match
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   INIZIO   start/restart; loads max = MIN_MANCHE + {PRIMO,SECONDO}
//   PRIMO    player 1 move (00 none, 01 sasso, 10 carta, 11 forbice)
//   SECONDO  player 2 move, same encoding
//   MANCHE   last manche result (00 invalid/none, 01 P1, 10 P2, 11 draw)
//   PARTITA  match result (00 ongoing/none, 01 P1, 10 P2, 11 draw)
//   PUNTI1   manches won by P1
//   PUNTI2   manches won by P2
//   GIOCATE  valid manches played
//
// Optional feature (macro MORRA_MOVE_LOCK_EN): the winner of the last decisive
// manche may not repeat the winning move in the next manche. If that player repeats it,
// the manche is invalid.

module morra_cinese_param #(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned MIN_MANCHE = 4,
    parameter int unsigned LEAD       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             INIZIO,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic [1:0]       PARTITA,
    output logic [CNT_W-1:0] PUNTI1,
    output logic [CNT_W-1:0] PUNTI2,
    output logic [CNT_W-1:0] GIOCATE
);

    typedef enum logic [1:0] {StIdle, StPlay, StEnd} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] max_q;

    logic             p1_win, p2_win, moves_ok, locked, valid;
    logic             lead_end, max_end;
    logic [CNT_W-1:0] g_upd, p1_upd, p2_upd, diff;
    logic [1:0]       manche_res, partita_res;

`ifdef MORRA_MOVE_LOCK_EN
    logic       lock_vld_q;
    logic       lock_p2_q;    // 0: P1 holds the lock, 1: P2
    logic [1:0] lock_move_q;

    assign locked = lock_vld_q &&
                    (lock_p2_q ? (SECONDO == lock_move_q) : (PRIMO == lock_move_q));
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        p1_win = (PRIMO == 2'b01 && SECONDO == 2'b11) ||
                 (PRIMO == 2'b11 && SECONDO == 2'b10) ||
                 (PRIMO == 2'b10 && SECONDO == 2'b01);
        p2_win = (SECONDO == 2'b01 && PRIMO == 2'b11) ||
                 (SECONDO == 2'b11 && PRIMO == 2'b10) ||
                 (SECONDO == 2'b10 && PRIMO == 2'b01);
        moves_ok = (PRIMO != 2'b00) && (SECONDO != 2'b00);
        valid    = moves_ok && !locked;

        // The end check uses the counts as they will be after this edge.
        g_upd  = GIOCATE + CNT_W'(valid);
        p1_upd = PUNTI1 + CNT_W'(valid && p1_win);
        p2_upd = PUNTI2 + CNT_W'(valid && p2_win);
        diff   = (p1_upd >= p2_upd) ? (p1_upd - p2_upd) : (p2_upd - p1_upd);

        lead_end = (g_upd >= CNT_W'(MIN_MANCHE)) && (diff >= CNT_W'(LEAD));
        max_end  = (g_upd == max_q);

        if (!valid)      manche_res = 2'b00;
        else if (p1_win) manche_res = 2'b01;
        else if (p2_win) manche_res = 2'b10;
        else             manche_res = 2'b11;

        if (p1_upd > p2_upd)      partita_res = 2'b01;
        else if (p2_upd > p1_upd) partita_res = 2'b10;
        else                      partita_res = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            max_q   <= '0;
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
            PUNTI1  <= '0;
            PUNTI2  <= '0;
            GIOCATE <= '0;
`ifdef MORRA_MOVE_LOCK_EN
            lock_vld_q  <= 1'b0;
            lock_p2_q   <= 1'b0;
            lock_move_q <= 2'b00;
`endif
        end else if (INIZIO) begin
            state_q <= StPlay;
            max_q   <= CNT_W'(MIN_MANCHE) + CNT_W'({PRIMO, SECONDO});
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
            PUNTI1  <= '0;
            PUNTI2  <= '0;
            GIOCATE <= '0;
`ifdef MORRA_MOVE_LOCK_EN
            lock_vld_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    MANCHE  <= 2'b00;
                    PARTITA <= 2'b00;
                    PUNTI1  <= '0;
                    PUNTI2  <= '0;
                    GIOCATE <= '0;
                end
                StPlay: begin
                    MANCHE  <= manche_res;
                    GIOCATE <= g_upd;
                    PUNTI1  <= p1_upd;
                    PUNTI2  <= p2_upd;
`ifdef MORRA_MOVE_LOCK_EN
                    if (valid) begin
                        lock_vld_q  <= p1_win || p2_win;
                        lock_p2_q   <= p2_win;
                        lock_move_q <= p2_win ? SECONDO : PRIMO;
                    end
`endif
                    if (lead_end) begin
                        PARTITA <= (p1_upd > p2_upd) ? 2'b01 : 2'b10;
                        state_q <= StEnd;
                    end else if (max_end) begin
                        PARTITA <= partita_res;
                        state_q <= StEnd;
                    end else begin
                        PARTITA <= 2'b00;
                    end
                end
                StEnd: begin
                    // Result and scores hold; moves are ignored.
                    MANCHE <= 2'b00;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
